// File: rtl/mem_pkg.sv
// Shared types and helpers for the latency_memory responder.
// Optional build macro used by the top level: LATENCY_MEM_OOB_CHECK_EN.
package mem_pkg;

  // One memory word as four byte lanes. Lane 0 is the least significant byte
  // of the 32-bit value that the storage array holds.
  typedef logic [0:3][7:0] mem_word_t;

  // Read-side controller states. IDLE is only seen straight out of reset.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } mem_state_t;

  // Default read latency. A refill that samples 4 cycles after issuing its
  // address needs this to be 3 or less.
  localparam int MEM_DEFAULT_LATENCY = 3;

  // Number of byte lanes in a word.
  localparam int MEM_LANES = 4;

  // Lanes to flat 32-bit word (lane 0 lands in bits [7:0]).
  function automatic logic [31:0] mem_pack(input mem_word_t w);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < MEM_LANES; i++) begin
      v[8*i +: 8] = w[i];
    end
    return v;
  endfunction

  // Flat 32-bit word to lanes (bits [7:0] land in lane 0).
  function automatic mem_word_t mem_unpack(input logic [31:0] v);
    mem_word_t w;
    w = '0;
    for (int i = 0; i < MEM_LANES; i++) begin
      w[i] = v[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for latency_memory: one synchronous write port and one
// synchronous read port with a registered, resettable read output.
// The storage itself is never reset.
module mem_array #(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [31:0]          rd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  // Write port: the word is updated on the strobed edge. A read on the same
  // edge still sees the old contents (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: the output register only changes when a load is requested,
  // otherwise it holds the last word read.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/latency_memory.sv
// latency_memory: word-organised main memory behind the data cache's
// refill / write-back port. Writes are posted and take effect on the strobed
// edge; reads return LATENCY edges after the address is captured.
//
// Optional build macro: LATENCY_MEM_OOB_CHECK_EN
//   defined   - addresses with any bit above ADDR_BITS+1 set are out of range:
//               such writes are dropped and pulse mem_err, such reads return 0
//               with mem_err held while the read is ready.
//   undefined - upper address bits are ignored (addresses alias), mem_err = 0.
//
// LATENCY must lie in 1..15 (cnt is 4 bits).
module latency_memory
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = MEM_DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] mem_addr,
  input  logic        mem_write_en,
  input  mem_word_t   mem_data_in,
  output mem_word_t   mem_data_out,
  output logic        mem_ready,
  output logic        mem_err
);

  // Port contract: there is no request/valid input. The word address on
  // mem_addr[31:2] is the read request; it is captured on an edge and
  // mem_ready rises LATENCY edges later if the address has held steady.
  // mem_ready drops on the same edge that captures a different word address,
  // and mem_data_out is only meaningful while mem_ready is high. Writes are
  // independent of this and are accepted on every edge with mem_write_en=1.

  mem_state_t           state;
  logic [3:0]           cnt;
  logic [31:0]          cap_addr;

  logic                 addr_chg;
  logic                 cnt_done;
  logic                 rd_load;
  logic                 wr_oob;
  logic                 wr_commit;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [ADDR_BITS-1:0] rd_idx;
  logic [31:0]          rd_word;
  logic                 unused_byte_offset;

  // Byte offset bits never select anything.
  assign unused_byte_offset = ^{mem_addr[1:0], cap_addr[1:0]};

  // A restart is triggered by any change of the full word address, even in
  // bits that alias onto the same array word.
  assign addr_chg = (mem_addr[31:2] != cap_addr[31:2]);
  assign cnt_done = (cnt == 4'(LATENCY));

  // Load the read register when a read completes, and keep reloading it
  // while READY so a write to the captured word shows up one edge later.
  assign rd_load  = !addr_chg &&
                    (((state == BUSY) && cnt_done) || (state == READY));

  assign wr_idx   = mem_addr[ADDR_BITS+1:2];
  assign rd_idx   = cap_addr[ADDR_BITS+1:2];

  // rst_b gates the strobe so a write on a reset edge is not committed.
  assign wr_commit = mem_write_en && rst_b && !wr_oob;

  mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .rst_b   (rst_b),
    .wr_en   (wr_commit),
    .wr_addr (wr_idx),
    .wr_data (mem_pack(mem_data_in)),
    .rd_en   (rd_load),
    .rd_addr (rd_idx),
    .rd_data (rd_word)
  );

  // Read controller: capture, count latency, then hold until the address moves.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_addr  <= 32'd0;
      mem_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cap_addr <= mem_addr;
          cnt      <= 4'd1;
          state    <= BUSY;
        end
        BUSY: begin
          if (addr_chg) begin
            cap_addr <= mem_addr;
            cnt      <= 4'd1;
          end else if (cnt_done) begin
            mem_ready <= 1'b1;
            state     <= READY;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        READY: begin
          if (addr_chg) begin
            cap_addr  <= mem_addr;
            cnt       <= 4'd1;
            mem_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 4'd0;
          mem_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef LATENCY_MEM_OOB_CHECK_EN
  logic cap_oob;
  logic rd_oob_q;
  logic wr_err_q;

  assign wr_oob  = ((mem_addr >> (ADDR_BITS + 2)) != 32'd0);
  assign cap_oob = ((cap_addr >> (ADDR_BITS + 2)) != 32'd0);

  // Remember whether the loaded read was out of range, and flag dropped writes
  // for exactly the cycle after the offending edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_oob_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= mem_write_en && wr_oob;
      if (rd_load) begin
        rd_oob_q <= cap_oob;
      end
    end
  end

  assign mem_err      = wr_err_q || (mem_ready && rd_oob_q);
  assign mem_data_out = rd_oob_q ? '0 : mem_unpack(rd_word);
`else
  assign wr_oob       = 1'b0;
  assign mem_err      = 1'b0;
  assign mem_data_out = mem_unpack(rd_word);
`endif

endmodule

// File: tb/tb_latency_memory.sv
// Bench for latency_memory: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_latency_memory;
  import mem_pkg::*;

  localparam int AB  = 16;
  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_b;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  mem_word_t   mem_data_in;
  mem_word_t   mem_data_out;
  logic        mem_ready;
  logic        mem_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  latency_memory #(
    .ADDR_BITS (AB),
    .LATENCY   (LAT)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_ready    (mem_ready),
    .mem_err      (mem_err)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_u32(input mem_word_t w);
    return {w[3], w[2], w[1], w[0]};
  endfunction

  function automatic mem_word_t from_u32(input logic [31:0] v);
    mem_word_t w;
    w[0] = v[7:0];
    w[1] = v[15:8];
    w[2] = v[23:16];
    w[3] = v[31:24];
    return w;
  endfunction

  function automatic logic is_oob(input logic [31:0] a);
`ifdef LATENCY_MEM_OOB_CHECK_EN
    return (a >> (AB + 2)) != 32'd0;
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  // ---------------- behavioural model ----------------
  // Memory contents keyed by aliased word index; the read side is modelled as
  // "which word was captured and how many edges ago".
  logic [31:0] mm [int];
  logic        m_idle;
  logic [29:0] m_cap;
  int          m_age;
  logic        e_ready;
  logic [31:0] e_data;
  logic        e_known;
  logic        e_err;

  task automatic model_reset();
    m_idle  = 1'b1;
    m_cap   = '0;
    m_age   = 0;
    e_ready = 1'b0;
    e_data  = '0;
    e_known = 1'b1;
    e_err   = 1'b0;
  endtask

  // Evaluated right after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    logic [29:0] w;
    int          idx;
    if (!rst_b) return;
    w = mem_addr[31:2];
    if (m_idle || (w != m_cap)) begin
      m_idle = 1'b0;
      m_cap  = w;
      m_age  = 0;
    end else if (m_age < 1000) begin
      m_age++;
    end
    e_ready = (m_age >= LAT);
    if (e_ready) begin
      idx = int'(m_cap[AB-1:0]);
      if (is_oob({m_cap, 2'b00})) begin
        e_data  = '0;
        e_known = 1'b1;
      end else if (mm.exists(idx)) begin
        e_data  = mm[idx];
        e_known = 1'b1;
      end else begin
        e_known = 1'b0;
      end
    end
    e_err = (mem_write_en && is_oob(mem_addr)) || (e_ready && is_oob({m_cap, 2'b00}));
    if (mem_write_en && !is_oob(mem_addr)) begin
      mm[int'(mem_addr[AB+1:2])] = to_u32(mem_data_in);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("ready", {31'd0, mem_ready}, {31'd0, e_ready});
      chk("err", {31'd0, mem_err}, {31'd0, e_err});
      if (!rst_b || (e_ready && e_known)) begin
        chk("data", to_u32(mem_data_out), e_data);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr     = a;
    mem_write_en = 1'b1;
    mem_data_in  = from_u32(d);
  endtask

  logic [31:0] pool [8];

  initial begin
    rst_b        = 1'b1;
    mem_addr     = '0;
    mem_write_en = 1'b0;
    mem_data_in  = '0;
    model_reset();
    pool = '{32'h0000_0040, 32'h0000_0041, 32'h0000_0080, 32'h0000_0100,
             32'h0000_0200, 32'h0000_0600, 32'h0003_FFFC, 32'h0004_0040};

    #2 rst_b = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_data", to_u32(mem_data_out), 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);

    // Preload words used by the directed scenarios.
    rst_b = 1'b1;
    set_wr(32'h40, 32'hDEAD_BEEF);  step();
    set_wr(32'h80, 32'h5566_7788);  step();
    set_wr(32'h600, 32'h0BAD_C0DE); step();
    mem_write_en = 1'b0;

    // Reset then hold 0x40: ready exactly 3 edges after the first capture.
    rst_b = 1'b0;
    model_reset();
    mem_addr = 32'h40;
    step();
    rst_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_ready", {31'd0, mem_ready}, (k == 3) ? 32'd1 : 32'd0);
    end
    chk("lane0", {24'd0, mem_data_out[0]}, 32'h0000_00EF);
    chk("lane1", {24'd0, mem_data_out[1]}, 32'h0000_00BE);
    chk("lane2", {24'd0, mem_data_out[2]}, 32'h0000_00AD);
    chk("lane3", {24'd0, mem_data_out[3]}, 32'h0000_00DE);

    // Posted write then read of the same word.
    set_wr(32'h100, 32'h1122_3344);
    step();
    mem_write_en = 1'b0;
    step();
    step();
    chk("pw_busy", {31'd0, mem_ready}, 32'd0);
    step();
    chk("pw_ready", {31'd0, mem_ready}, 32'd1);
    chk("pw_data", to_u32(mem_data_out), 32'h1122_3344);

    // Address change at cnt=2 restarts the latency count.
    mem_addr = 32'h40; step();
    step();
    mem_addr = 32'h80; step();
    step();
    step();
    chk("chg_busy", {31'd0, mem_ready}, 32'd0);
    step();
    chk("chg_ready", {31'd0, mem_ready}, 32'd1);
    chk("chg_data", to_u32(mem_data_out), 32'h5566_7788);

    // Write-back then refill from a different word.
    set_wr(32'h200, 32'hCAFE_F00D);
    step();
    mem_write_en = 1'b0;
    mem_addr     = 32'h600;
    for (int k = 0; k < 4; k++) step();
    chk("wb_ready", {31'd0, mem_ready}, 32'd1);
    chk("wb_refill", to_u32(mem_data_out), 32'h0BAD_C0DE);
    mem_addr = 32'h200;
    for (int k = 0; k < 4; k++) step();
    chk("wb_data", to_u32(mem_data_out), 32'hCAFE_F00D);

    // Reset asserted mid-BUSY together with a write.
    mem_addr = 32'h300;
    step();
    set_wr(32'h200, 32'h9999_9999);
    rst_b = 1'b0;
    model_reset();
    #1;
    chk("rstb_ready", {31'd0, mem_ready}, 32'd0);
    chk("rstb_data", to_u32(mem_data_out), 32'd0);
    chk("rstb_err", {31'd0, mem_err}, 32'd0);
    step();
    rst_b        = 1'b1;
    mem_write_en = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("rstb_ready2", {31'd0, mem_ready}, 32'd1);
    chk("rstb_nowrite", to_u32(mem_data_out), 32'hCAFE_F00D);

`ifdef LATENCY_MEM_OOB_CHECK_EN
    set_wr(32'h0, 32'h1234_5678); step();
    set_wr(32'h0004_0000, 32'hFFFF_0000); step();
    chk("oob_wr_err", {31'd0, mem_err}, 32'd1);
    mem_write_en = 1'b0;
    step();
    chk("oob_wr_pulse", {31'd0, mem_err}, 32'd0);
    for (int k = 0; k < 3; k++) step();
    chk("oob_rd_data", to_u32(mem_data_out), 32'd0);
    chk("oob_rd_err", {31'd0, mem_err}, 32'd1);
    mem_addr = 32'h0;
    for (int k = 0; k < 4; k++) step();
    chk("oob_word0", to_u32(mem_data_out), 32'h1234_5678);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) mem_addr = pool[$urandom_range(0, 7)];
      mem_write_en = ($urandom_range(0, 3) == 0);
      mem_data_in  = from_u32($urandom());
      if ($urandom_range(0, 399) == 0) begin
        rst_b = 1'b0;
        model_reset();
      end else begin
        rst_b = 1'b1;
      end
      step();
    end
    rst_b        = 1'b1;
    mem_write_en = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
